// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI read channel (AR/R) among NUM_MASTERS refill engines.
// Optional burst-length checker enabled by defining AXI_ARB_LEN_CHECK_EN.
module axi_read_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int LEN_WIDTH   = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_MASTERS-1:0]            m_ar_valid,
  output logic [NUM_MASTERS-1:0]            m_ar_ready,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_ar_addr,
  input  logic [NUM_MASTERS*LEN_WIDTH-1:0]  m_ar_len,
  input  logic [NUM_MASTERS*3-1:0]          m_ar_size,
  output logic [NUM_MASTERS-1:0]            m_r_valid,
  input  logic [NUM_MASTERS-1:0]            m_r_ready,
  output logic [DATA_WIDTH-1:0]             m_r_data,
  output logic                              m_r_last,
  output logic                              axi_ar_valid,
  input  logic                              axi_ar_ready,
  output logic [ADDR_WIDTH-1:0]             axi_ar_addr,
  output logic [LEN_WIDTH-1:0]              axi_ar_len,
  output logic [2:0]                        axi_ar_size,
  input  logic                              axi_r_valid,
  output logic                              axi_r_ready,
  input  logic [DATA_WIDTH-1:0]             axi_r_data,
  input  logic                              axi_r_last,
  output logic [NUM_MASTERS-1:0]            grant,
  output logic                              busy,
  output logic                              err_len
);

  localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SUM_W = PTR_W + 1;
  localparam int CNT_W = LEN_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                 state;
  logic [PTR_W-1:0]       rr_ptr;
  logic [PTR_W-1:0]       gnt_idx;
  logic [CNT_W-1:0]       beat_cnt;
  logic [ADDR_WIDTH-1:0]  ar_addr;
  logic [LEN_WIDTH-1:0]   ar_len;
  logic [2:0]             ar_size;

  logic [ADDR_WIDTH-1:0]  addr_arr [NUM_MASTERS];
  logic [LEN_WIDTH-1:0]   len_arr  [NUM_MASTERS];
  logic [2:0]             size_arr [NUM_MASTERS];

  logic                   pick_valid;
  logic [PTR_W-1:0]       pick_idx;
  logic [NUM_MASTERS-1:0] pick_onehot;
  logic                   r_hs;

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
    assign addr_arr[i] = m_ar_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign len_arr[i]  = m_ar_len[i*LEN_WIDTH +: LEN_WIDTH];
    assign size_arr[i] = m_ar_size[i*3 +: 3];
  end

  // Search from rr_ptr upward with an explicit wrap so non-power-of-two counts work.
  always_comb begin : arb
    logic [SUM_W-1:0] sum;
    logic [PTR_W-1:0] cand;
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    pick_valid  = 1'b0;
    pick_idx    = '0;
    pick_onehot = '0;
    sum         = '0;
    cand        = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      sum = {1'b0, rr_ptr} + SUM_W'(k);
      if (sum >= SUM_W'(NUM_MASTERS)) sum = sum - SUM_W'(NUM_MASTERS);
      cand = sum[PTR_W-1:0];
      if (!pick_valid && m_ar_valid[cand]) begin
        pick_valid        = 1'b1;
        pick_idx          = cand;
        pick_onehot[cand] = 1'b1;
      end
    end
  end

  // The request handshake completes in the IDLE cycle itself; gating with reset keeps it quiet during reset.
  assign m_ar_ready   = (state == IDLE && reset) ? pick_onehot : '0;
  assign axi_ar_valid = (state == ADDR);
  assign axi_ar_addr  = ar_addr;
  assign axi_ar_len   = ar_len;
  assign axi_ar_size  = ar_size;
  assign axi_r_ready  = (state == DATA) && m_r_ready[gnt_idx];
  assign m_r_valid    = (state == DATA && axi_r_valid) ? grant : '0;
  assign m_r_data     = (state == DATA) ? axi_r_data : '0;
  assign m_r_last     = (state == DATA) && axi_r_last;
  assign busy         = (state != IDLE);
  assign r_hs         = axi_r_valid && axi_r_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gnt_idx  <= '0;
      grant    <= '0;
      beat_cnt <= '0;
      ar_addr  <= '0;
      ar_len   <= '0;
      ar_size  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state   <= ADDR;
            gnt_idx <= pick_idx;
            grant   <= pick_onehot;
            ar_addr <= addr_arr[pick_idx];
            ar_len  <= len_arr[pick_idx];
            ar_size <= size_arr[pick_idx];
          end
        end
        ADDR: begin
          if (axi_ar_ready) state <= DATA;
        end
        DATA: begin
          if (r_hs) begin
            if (axi_r_last) begin
              state    <= IDLE;
              grant    <= '0;
              beat_cnt <= '0;
              rr_ptr   <= (gnt_idx == PTR_W'(NUM_MASTERS - 1)) ? '0 : gnt_idx + 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AXI_ARB_LEN_CHECK_EN
  logic err_q;
  logic len_mismatch;

  // beat_cnt is the index of the beat being transferred, so the final beat must see beat_cnt == len.
  assign len_mismatch = axi_r_last ? (beat_cnt != {1'b0, ar_len})
                                   : (beat_cnt == {1'b0, ar_len});

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (r_hs && len_mismatch) begin
      err_q <= 1'b1;
    end
  end

  assign err_len = err_q;
`else
  assign err_len = 1'b0;
`endif

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Shares the single AXI read channel (AR/R) of the cache subsystem between several refill requesters, e.g. master 0 = dcache refill and master 1 = icache refill.
- Only one transaction is outstanding at a time. Grants are round-robin.
- Holds AR stable until the handshake completes, then routes the R burst back to the granted master only.
- Sits between the cache refill units (AXI read engines) and the top-level AXI port.

Parameters:
NUM_MASTERS, 2, number of requesters (2..4)
ADDR_WIDTH, 32, AR address width
DATA_WIDTH, 32, R data width
LEN_WIDTH, 4, arlen width (beats = len+1)

Ports:
clock  in  1  single clock
reset  in  1  asynchronous, active-low reset
m_ar_valid  in  NUM_MASTERS  per-master request valid
m_ar_ready  out  NUM_MASTERS  per-master request accept
m_ar_addr  in  NUM_MASTERS*ADDR_WIDTH  per-master address, master i at slice i
m_ar_len  in  NUM_MASTERS*LEN_WIDTH  per-master burst length
m_ar_size  in  NUM_MASTERS*3  per-master beat size
m_r_valid  out  NUM_MASTERS  per-master beat valid
m_r_ready  in  NUM_MASTERS  per-master beat accept
m_r_data  out  DATA_WIDTH  R data, broadcast to all masters
m_r_last  out  1  R last, broadcast to all masters
axi_ar_valid  out  1  downstream AR valid
axi_ar_ready  in  1  downstream AR ready
axi_ar_addr  out  ADDR_WIDTH  latched address
axi_ar_len  out  LEN_WIDTH  latched length
axi_ar_size  out  3  latched size
axi_r_valid  in  1  downstream R valid
axi_r_ready  out  1  downstream R ready
axi_r_data  in  DATA_WIDTH  downstream R data
axi_r_last  in  1  downstream R last
grant  out  NUM_MASTERS  one-hot owner of the channel, 0 when idle
busy  out  1  state != IDLE
err_len  out  1  sticky burst-length error (see Optional Feature)

Behaviour:
- FSM states: IDLE, ADDR, DATA.
- Reset values: state=IDLE, rr_ptr=0, beat_cnt=0. All outputs are 0, including grant, axi_ar_addr/len/size and err_len.
- IDLE:
  - Pick the first master i with m_ar_valid[i], searching from rr_ptr upward modulo NUM_MASTERS.
  - Pulse m_ar_ready[i]=1 for that cycle only. This completes the master's handshake in the same cycle.
  - Latch addr/len/size. Set grant to one-hot i. Go to ADDR.
  - If no request is valid, stay in IDLE.
- ADDR:
  - axi_ar_valid=1, with the latched fields held stable until axi_ar_ready=1. Then go to DATA.
  - Latency: master request to axi_ar_valid is exactly 1 cycle.
- DATA:
  - axi_r_ready = m_r_ready[grant].
  - m_r_valid[grant] = axi_r_valid. All other m_r_valid bits are 0.
  - m_r_data and m_r_last pass combinationally from axi_r_data and axi_r_last.
  - beat_cnt increments on each R handshake.
  - On a handshake with axi_r_last=1: go to IDLE, clear grant, rr_ptr = (granted index + 1) mod NUM_MASTERS, beat_cnt=0.
- m_ar_ready is 0 for every master in ADDR and DATA. Requests that arrive during a burst wait.
- The cycle that returns to IDLE grants nothing. The next grant occurs no earlier than the following cycle, so back-to-back bursts have a 1-cycle gap.
- Simultaneous requests: the master at or after rr_ptr wins. A master that keeps requesting never starves the others.
- Stray axi_r_valid in IDLE or ADDR: axi_r_ready=0, no m_r_valid is asserted, and the beat is not consumed.
- Reset mid-burst: asynchronous return to IDLE, and all outputs drop immediately. Any partial burst is abandoned. The whole AXI fabric is reset together, so the downstream side does not complete it.
- Arithmetic widths:
  - beat_cnt is LEN_WIDTH+1 bits wide.
  - rr_ptr is clog2(NUM_MASTERS) bits wide, with an explicit wrap at NUM_MASTERS-1 (values ≥ NUM_MASTERS are never reachable).

Optional Feature:
- Macro: AXI_ARB_LEN_CHECK_EN.
- Defined:
  - err_len is set, and stays set until reset, when an R handshake has axi_r_last=1 while beat_cnt != latched len.
  - err_len is also set when an R handshake without last occurs while beat_cnt == latched len.
  - In the second case the FSM still waits for last. Routing is unaffected in both cases.
- Not defined: err_len is tied to 0 and there is no check logic. The port still exists.

Test Plan:
- Single request: m0 requests addr=0x1000_0040, len=3 → m_ar_ready[0] pulses in cycle 0, and axi_ar_valid rises in cycle 1 with addr 0x1000_0040, len 3. Then 4 R beats D0..D3 reach only m0, with m_r_last on D3, and grant returns to 0 one cycle after the last beat.
- Contention: m0 and m1 both request continuously from reset → grants alternate 0,1,0,1. Each m_ar_ready pulse arrives exactly 1 cycle after the previous burst's last beat.
- Backpressure: axi_ar_ready held low for 5 cycles → axi_ar_addr/len/size stay constant throughout. Then m1 holds m_r_ready low for 3 cycles mid-burst → axi_r_ready stays low for those cycles and no beat is lost.
- Stray beat: axi_r_valid=1 while idle → axi_r_ready=0 and all m_r_valid=0.
- Reset mid-burst: reset is asserted after 2 of 4 beats → grant, busy and axi_ar_valid drop immediately. After reset is released, m1 is granted first, because rr_ptr has reset to 0 and m0 is not requesting.
- With AXI_ARB_LEN_CHECK_EN: len=3 and r_last arrives on the 2nd beat → err_len=1 from the next cycle and stays 1 until reset. Without the macro, err_len stays 0.
